// File: rtl/uart_rx_sync_pkg.sv
// Shared types and helpers for the mid-bit-sampling UART receiver.
package uart_rx_sync_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } rx_state_t;

  // parity_mode encodings, identical to the transmitter's
  localparam logic [1:0] PAR_ODD   = 2'b11;
  localparam logic [1:0] PAR_EVEN  = 2'b10;
  localparam logic [1:0] PAR_MARK  = 2'b01;
  localparam logic [1:0] PAR_SPACE = 2'b00;

  // 18 bits covers the slowest setting: (2*650) << 7 = 166400
  localparam int TIMER_W = 18;

  // Bit period in clk cycles for a half-period count h and a divider exponent
  function automatic logic [TIMER_W-1:0] bit_cycles(input int h, input logic [2:0] div);
    logic [TIMER_W-1:0] base;
    base = TIMER_W'(2 * h);
    return base << div;
  endfunction

  // 2-of-3 vote over the three samples taken inside one bit
  function automatic logic majority3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Parity bit the transmitter would have sent for these data bits
  function automatic logic expected_parity(input logic [1:0] mode, input logic [7:0] bits);
    logic p;
    case (mode)
      PAR_ODD:   p = ~(^bits);
      PAR_EVEN:  p = ^bits;
      PAR_MARK:  p = 1'b1;
      PAR_SPACE: p = 1'b0;
      default:   p = 1'b0;
    endcase
    return p;
  endfunction

endpackage

// File: rtl/uart_rx_sync_bit_timer.sv
// Bit-period timer: latches the baud setting at frame start, counts 0..BIT-1
// and raises single-cycle strobes at the three sample points and at the wrap.
module uart_rx_sync_bit_timer
  import uart_rx_sync_pkg::*;
#(
  parameter int H0 = 650,
  parameter int H1 = 108
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       run,
  input  logic       base_sel,
  input  logic [2:0] div_ratio,
  output logic       samp_early,
  output logic       samp_mid,
  output logic       samp_late,
  output logic       wrap
);

  logic [TIMER_W-1:0] bit_len;
  logic [TIMER_W-1:0] timer;
  logic [TIMER_W-1:0] half;
  logic [TIMER_W-1:0] q;

  assign half = bit_len >> 1;
  assign q    = bit_len >> 4;

  assign samp_early = run && (timer == half - q);
  assign samp_mid   = run && (timer == half);
  assign samp_late  = run && (timer == half + q);
  assign wrap       = run && (timer == bit_len - TIMER_W'(1));

  // Latch the bit period at frame start, then free-run and wrap every bit
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_len <= '0;
      timer   <= '0;
    end else if (start) begin
      bit_len <= bit_cycles(base_sel ? H1 : H0, div_ratio);
      timer   <= '0;
    end else if (run) begin
      timer <= wrap ? '0 : timer + TIMER_W'(1);
    end
  end

endmodule

// File: rtl/uart_rx_sync.sv
// Single-clock UART receiver with 2-flop input synchronizer, 3-sample majority
// voting per bit, false-start rejection and parity/framing error reporting.
module uart_rx_sync
  import uart_rx_sync_pkg::*;
#(
  parameter int inCLK_PERIOD_ns = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       baseClock_freq,
  input  logic [2:0] divRatio,
  input  logic       data_size,
  input  logic       parity_en,
  input  logic [1:0] parity_mode,
  input  logic       stop_bit_size,
  input  logic       rx,
  output logic [7:0] data,
  output logic       newData,
  output logic       parity_err,
  output logic       frame_err,
  output logic       ready
);

  localparam int H0 = 6500 / inCLK_PERIOD_ns;
  localparam int H1 = 1080 / inCLK_PERIOD_ns;

  rx_state_t state, next_state;

  logic       rx_meta, rx_s, rx_prev;
  logic       fall;
  logic       samp_early, samp_mid, samp_late, wrap;
  logic       samp_a, samp_b;
  logic       vote;

  // frame configuration captured at start detection
  logic       cfg_size, cfg_par_en, cfg_two_stop;
  logic [1:0] cfg_par_mode;

  logic [2:0] bit_idx;
  logic [2:0] last_bit;
  logic       stop_idx;
  logic [7:0] data_buff;
  logic       parity_err_int, frame_err_int;

  // FSM-issued actions for the datapath
  logic       do_start, do_shift, do_parity, do_stop, do_finish, adv_bit, adv_stop;

  assign fall     = rx_prev & ~rx_s;
  assign vote     = majority3(samp_a, samp_b, rx_s);
  assign last_bit = cfg_size ? 3'd7 : 3'd6;
  assign ready    = (state == ST_IDLE);

  uart_rx_sync_bit_timer #(
    .H0(H0),
    .H1(H1)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .start      (do_start),
    .run        (state != ST_IDLE),
    .base_sel   (baseClock_freq),
    .div_ratio  (divRatio),
    .samp_early (samp_early),
    .samp_mid   (samp_mid),
    .samp_late  (samp_late),
    .wrap       (wrap)
  );

  // Bring rx into the clk domain and keep one cycle of history for edge detection
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      rx_meta <= rx;
      rx_s    <= rx_meta;
      rx_prev <= rx_s;
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_IDLE;
    else      state <= next_state;
  end

  // FSM next state and datapath actions; the late sample is the voting point
  always_comb begin
    next_state = state;
    do_start   = 1'b0;
    do_shift   = 1'b0;
    do_parity  = 1'b0;
    do_stop    = 1'b0;
    do_finish  = 1'b0;
    adv_bit    = 1'b0;
    adv_stop   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (fall) begin
          do_start   = 1'b1;
          next_state = ST_START;
        end
      end
      ST_START: begin
        if (samp_late && vote) next_state = ST_IDLE;
        else if (wrap)         next_state = ST_DATA;
      end
      ST_DATA: begin
        if (samp_late) do_shift = 1'b1;
        if (wrap) begin
          if (bit_idx == last_bit) next_state = cfg_par_en ? ST_PARITY : ST_STOP;
          else                     adv_bit = 1'b1;
        end
      end
      ST_PARITY: begin
        if (samp_late) do_parity = 1'b1;
        if (wrap)      next_state = ST_STOP;
      end
      ST_STOP: begin
        if (samp_late) begin
          do_stop = 1'b1;
          // the final stop bit finishes the frame without waiting for its end
          if (stop_idx == cfg_two_stop) begin
            do_finish  = 1'b1;
            next_state = ST_IDLE;
          end
        end else if (wrap) begin
          adv_stop = 1'b1;
        end
      end
      default: next_state = ST_IDLE;
    endcase
  end

  // Frame datapath: config capture, sample capture, shifter and error flags
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cfg_size       <= 1'b0;
      cfg_par_en     <= 1'b0;
      cfg_par_mode   <= 2'b00;
      cfg_two_stop   <= 1'b0;
      samp_a         <= 1'b1;
      samp_b         <= 1'b1;
      bit_idx        <= 3'd0;
      stop_idx       <= 1'b0;
      data_buff      <= 8'h00;
      parity_err_int <= 1'b0;
      frame_err_int  <= 1'b0;
    end else begin
      if (do_start) begin
        cfg_size       <= data_size;
        cfg_par_en     <= parity_en;
        cfg_par_mode   <= parity_mode;
        cfg_two_stop   <= stop_bit_size;
        bit_idx        <= 3'd0;
        stop_idx       <= 1'b0;
        data_buff      <= 8'h00;
        parity_err_int <= 1'b0;
        frame_err_int  <= 1'b0;
      end
      if (samp_early) samp_a <= rx_s;
      if (samp_mid)   samp_b <= rx_s;
      if (do_shift)   data_buff[bit_idx] <= vote;
      if (adv_bit)    bit_idx <= bit_idx + 3'd1;
      if (do_parity)  parity_err_int <= (vote != expected_parity(cfg_par_mode, data_buff));
      if (do_stop && !vote) frame_err_int <= 1'b1;
      if (adv_stop)   stop_idx <= 1'b1;
    end
  end

  // Output register: results replace the previous frame's on each completion
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data       <= 8'h00;
      newData    <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      newData <= do_finish;
      if (do_finish) begin
        data       <= data_buff;
        parity_err <= parity_err_int;
        frame_err  <= frame_err_int | ~vote;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_sync.sv
// Self-checking bench for uart_rx_sync: directed scenarios plus randomized frames
// compared against a frame-level model of the serial protocol.
module tb_uart_rx_sync;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       baseClock_freq;
  logic [2:0] divRatio;
  logic       data_size;
  logic       parity_en;
  logic [1:0] parity_mode;
  logic       stop_bit_size;
  logic       rx;
  logic [7:0] data;
  logic       newData;
  logic       parity_err;
  logic       frame_err;
  logic       ready;

  int vectors = 0;
  int miscompares = 0;
  int nd_count = 0;
  logic [7:0] cap_data;
  logic       cap_pe, cap_fe;

  always #5 clk = ~clk;

  uart_rx_sync #(.inCLK_PERIOD_ns(10)) dut (
    .clk            (clk),
    .rst            (rst_n),
    .baseClock_freq (baseClock_freq),
    .divRatio       (divRatio),
    .data_size      (data_size),
    .parity_en      (parity_en),
    .parity_mode    (parity_mode),
    .stop_bit_size  (stop_bit_size),
    .rx             (rx),
    .data           (data),
    .newData        (newData),
    .parity_err     (parity_err),
    .frame_err      (frame_err),
    .ready          (ready)
  );

  // record every completion pulse, sampled away from the active edge
  always @(negedge clk) begin
    if (newData === 1'b1) begin
      nd_count++;
      cap_data = data;
      cap_pe   = parity_err;
      cap_fe   = frame_err;
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // line-level model: bit period and parity bit from the protocol definition
  function automatic int bit_len(input logic base, input logic [2:0] div);
    return (2 * (base ? 108 : 650)) << div;
  endfunction

  function automatic logic par_bit(input logic [1:0] mode, input logic [7:0] d);
    int ones;
    ones = $countones(d);
    case (mode)
      2'b11:   return (ones % 2 == 0);   // odd: total ones odd
      2'b10:   return (ones % 2 == 1);   // even: total ones even
      2'b01:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Drive one complete frame onto rx; optional 1-clk glitch in a data bit and
  // optional scrambling of the config inputs once the frame is under way.
  task automatic send_frame(input logic [7:0] b, input logic base, input logic [2:0] div,
                            input logic size, input logic pen, input logic [1:0] pmode,
                            input logic two, input logic flip, input logic s1, input logic s2,
                            input int glitch_bit, input logic scramble);
    logic [7:0] d;
    int blen;
    d = size ? b : {1'b0, b[6:0]};
    blen = bit_len(base, div);
    baseClock_freq = base; divRatio = div; data_size = size;
    parity_en = pen; parity_mode = pmode; stop_bit_size = two;
    rx = 1'b1; tick(4);
    rx = 1'b0;
    if (scramble) begin
      tick(blen / 4);
      baseClock_freq = 1'($urandom); divRatio = 3'($urandom); data_size = 1'($urandom);
      parity_en = 1'($urandom); parity_mode = 2'($urandom); stop_bit_size = 1'($urandom);
      tick(blen - blen / 4);
    end else begin
      tick(blen);
    end
    for (int i = 0; i < (size ? 8 : 7); i++) begin
      rx = d[i];
      if (i == glitch_bit) begin
        // lands on the middle sample of the bit
        tick(blen / 2 + 1); rx = ~d[i]; tick(1); rx = d[i]; tick(blen - blen / 2 - 2);
      end else begin
        tick(blen);
      end
    end
    if (pen) begin rx = par_bit(pmode, d) ^ flip; tick(blen); end
    rx = s1; tick(blen);
    if (two) begin rx = s2; tick(blen); end
    rx = 1'b1; tick(4);
  endtask

  task automatic test_reset;
    rx = 1'b1; rst_n = 1'b0;
    baseClock_freq = 1'b1; divRatio = 3'd0; data_size = 1'b1;
    parity_en = 1'b0; parity_mode = 2'b00; stop_bit_size = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(2);
    vectors++; if (data !== 8'h00) begin miscompares++; $display("FAIL reset_data: got %h want 00", data); end
    vectors++; if (newData !== 1'b0) begin miscompares++; $display("FAIL reset_newData: got %b want 0", newData); end
    vectors++; if (parity_err !== 1'b0) begin miscompares++; $display("FAIL reset_parity_err: got %b want 0", parity_err); end
    vectors++; if (frame_err !== 1'b0) begin miscompares++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", ready); end
  endtask

  task automatic test_8n1;
    int n0;
    n0 = nd_count;
    send_frame(8'hA5, 1'b1, 3'd0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, -1, 1'b0);
    vectors++; if (nd_count - n0 !== 1) begin miscompares++; $display("FAIL 8n1_pulses: got %0d want 1", nd_count - n0); end
    vectors++; if (cap_data !== 8'hA5) begin miscompares++; $display("FAIL 8n1_data: got %h want a5", cap_data); end
    vectors++; if (cap_pe !== 1'b0 || cap_fe !== 1'b0) begin miscompares++; $display("FAIL 8n1_flags: got pe=%b fe=%b want 0 0", cap_pe, cap_fe); end
    vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL 8n1_ready: got %b want 1", ready); end
  endtask

  task automatic test_7e1;
    send_frame(8'h53, 1'b1, 3'd0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b0, 1'b1, 1'b1, -1, 1'b0);
    vectors++; if (cap_data !== 8'h53) begin miscompares++; $display("FAIL 7e1_data: got %h want 53", cap_data); end
    vectors++; if (cap_pe !== 1'b0) begin miscompares++; $display("FAIL 7e1_pe_good: got %b want 0", cap_pe); end
    send_frame(8'h53, 1'b1, 3'd0, 1'b0, 1'b1, 2'b10, 1'b0, 1'b1, 1'b1, 1'b1, -1, 1'b0);
    vectors++; if (cap_data !== 8'h53) begin miscompares++; $display("FAIL 7e1_flip_data: got %h want 53", cap_data); end
    vectors++; if (cap_pe !== 1'b1) begin miscompares++; $display("FAIL 7e1_pe_bad: got %b want 1", cap_pe); end
  endtask

  task automatic test_8o2;
    send_frame(8'h00, 1'b1, 3'd0, 1'b1, 1'b1, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0, -1, 1'b0);
    vectors++; if (cap_fe !== 1'b1) begin miscompares++; $display("FAIL 8o2_fe_stop2: got %b want 1", cap_fe); end
    vectors++; if (cap_pe !== 1'b0 || cap_data !== 8'h00) begin miscompares++; $display("FAIL 8o2_pe_data: got pe=%b data=%h want 0 00", cap_pe, cap_data); end
    send_frame(8'h00, 1'b1, 3'd0, 1'b1, 1'b1, 2'b11, 1'b1, 1'b0, 1'b1, 1'b1, -1, 1'b0);
    vectors++; if (cap_fe !== 1'b0) begin miscompares++; $display("FAIL 8o2_fe_clean: got %b want 0", cap_fe); end
  endtask

  task automatic test_false_start;
    int n0;
    n0 = nd_count;
    rx = 1'b0; tick(40);
    vectors++; if (ready !== 1'b0) begin miscompares++; $display("FAIL fstart_busy: got ready=%b want 0", ready); end
    tick(40);
    rx = 1'b1; tick(3 * 216);
    vectors++; if (nd_count !== n0) begin miscompares++; $display("FAIL fstart_no_pulse: got %0d pulses want 0", nd_count - n0); end
    vectors++; if (ready !== 1'b1) begin miscompares++; $display("FAIL fstart_ready: got %b want 1", ready); end
  endtask

  task automatic test_glitch;
    send_frame(8'h96, 1'b1, 3'd0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 3, 1'b0);
    vectors++; if (cap_data !== 8'h96) begin miscompares++; $display("FAIL glitch_data: got %h want 96", cap_data); end
    send_frame(8'h69, 1'b1, 3'd0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0);
    vectors++; if (cap_data !== 8'h69) begin miscompares++; $display("FAIL glitch_data_b0: got %h want 69", cap_data); end
  endtask

  task automatic test_break;
    int n0;
    baseClock_freq = 1'b1; divRatio = 3'd0; data_size = 1'b1;
    parity_en = 1'b0; parity_mode = 2'b00; stop_bit_size = 1'b0;
    n0 = nd_count;
    rx = 1'b0; tick(14 * 216);
    vectors++; if (nd_count - n0 !== 1) begin miscompares++; $display("FAIL break_pulses: got %0d want 1", nd_count - n0); end
    vectors++; if (cap_data !== 8'h00 || cap_fe !== 1'b1) begin miscompares++; $display("FAIL break_result: got data=%h fe=%b want 00 1", cap_data, cap_fe); end
    rx = 1'b1; tick(300);
    vectors++; if (nd_count - n0 !== 1) begin miscompares++; $display("FAIL break_single: got %0d pulses want 1", nd_count - n0); end
  endtask

  task automatic test_random;
    logic [7:0] b, exp_d;
    logic size, pen, two, flip, s1, s2, exp_pe, exp_fe;
    logic [1:0] pm;
    logic [2:0] div;
    int n0;
    for (int k = 0; k < 8; k++) begin
      b = 8'($urandom); size = 1'($urandom); pen = 1'($urandom); two = 1'($urandom);
      pm = 2'($urandom); div = 3'($urandom_range(0, 1));
      flip = ($urandom_range(0, 3) == 0); s1 = ($urandom_range(0, 3) != 0); s2 = ($urandom_range(0, 3) != 0);
      exp_d  = size ? b : (b & 8'h7F);
      exp_pe = pen & flip;
      exp_fe = ~s1 | (two & ~s2);
      n0 = nd_count;
      send_frame(b, 1'b1, div, size, pen, pm, two, flip, s1, s2, -1, 1'b1);
      vectors++; if (nd_count - n0 !== 1) begin miscompares++; $display("FAIL rand%0d_pulses: got %0d want 1", k, nd_count - n0); end
      vectors++; if ({cap_data, cap_pe, cap_fe} !== {exp_d, exp_pe, exp_fe}) begin
        miscompares++;
        $display("FAIL rand%0d_frame: got data=%h pe=%b fe=%b want data=%h pe=%b fe=%b", k, cap_data, cap_pe, cap_fe, exp_d, exp_pe, exp_fe);
      end
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] d;
    int n0;
    d = 8'hF7;
    baseClock_freq = 1'b1; divRatio = 3'd0; data_size = 1'b1;
    parity_en = 1'b0; parity_mode = 2'b00; stop_bit_size = 1'b0;
    rx = 1'b1; tick(4);
    rx = 1'b0; tick(216);
    for (int i = 0; i < 4; i++) begin rx = d[i]; tick(216); end
    rx = d[4]; tick(100);
    n0 = nd_count;
    rst_n = 1'b0; #1;
    vectors++; if ({data, newData, parity_err, frame_err, ready} !== {8'h00, 4'b0001}) begin
      miscompares++;
      $display("FAIL midreset_outputs: got data=%h nd=%b pe=%b fe=%b rdy=%b want 00 0 0 0 1", data, newData, parity_err, frame_err, ready);
    end
    rx = 1'b1; tick(3);
    rst_n = 1'b1; tick(20);
    vectors++; if (nd_count !== n0) begin miscompares++; $display("FAIL midreset_no_pulse: got %0d pulses want 0", nd_count - n0); end
    send_frame(8'h3C, 1'b1, 3'd0, 1'b1, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1, -1, 1'b0);
    vectors++; if (nd_count - n0 !== 1 || cap_data !== 8'h3C) begin
      miscompares++;
      $display("FAIL midreset_next: got pulses=%0d data=%h want 1 3c", nd_count - n0, cap_data);
    end
  endtask

  initial begin
    test_reset();
    test_8n1();
    test_7e1();
    test_8o2();
    test_false_start();
    test_glitch();
    test_break();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
